// File: rtl/alu_ctrl_pkg.sv
// Shared opcode constants, FSM state encoding and the legal-opcode check
// for the ALU operation controller.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_A    = 4'b0000;
  localparam logic [3:0] OP_B    = 4'b0001;
  localparam logic [3:0] OP_SUM  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0011;
  localparam logic [3:0] OP_CMUL = 4'b0100;
  localparam logic [3:0] OP_RMUL = 4'b0110;
  localparam logic [3:0] OP_EQ   = 4'b1000;
  localparam logic [3:0] OP_MODA = 4'b1001;
  localparam logic [3:0] OP_MODB = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    logic legal;
    case (op)
      OP_A, OP_B, OP_SUM, OP_SUB, OP_CMUL,
      OP_RMUL, OP_EQ, OP_MODA, OP_MODB: legal = 1'b1;
      default:                          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/alu_op_controller_if.sv
// Request/ALU handshake bundle between a requester (master) and the
// operation controller (slave).
interface alu_op_controller_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 6
);
  logic              start;
  logic [3:0]        opr;
  logic [CNT_W-1:0]  maxclock;
  logic              done;
  logic [DATA_W-1:0] alu_result;
  logic              alu_go;
  logic [3:0]        alu_op;
  logic              busy;
  logic [DATA_W-1:0] out;
  logic              out_valid;
  logic              timeout;
  logic              illegal_op;

  modport master (
    output start, opr, maxclock, done, alu_result,
    input  alu_go, alu_op, busy, out, out_valid, timeout, illegal_op
  );

  modport slave (
    input  start, opr, maxclock, done, alu_result,
    output alu_go, alu_op, busy, out, out_valid, timeout, illegal_op
  );
endinterface

// File: rtl/op_timer.sv
// WAIT-phase cycle counter; expired flags that the count has reached the
// latched limit.
module op_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] cnt_r;

  // Wait counter: cleared outside WAIT, advanced while still waiting.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = (cnt_r == limit);

endmodule

// File: rtl/alu_op_controller.sv
// Launches one ALU operation per accepted start, waits for done with a
// per-operation timeout and registers the result.
module alu_op_controller
  import alu_ctrl_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  alu_op_controller_if.slave   bus
);

  state_t            state_r;
  state_t            state_next_s;
  logic              op_legal_s;
  logic              accept_s;
  logic              expired_s;
  logic              timer_clear_s;
  logic              timer_enable_s;
  logic              alu_go_next_s;
  logic              busy_next_s;
  logic              out_valid_next_s;
  logic              timeout_next_s;
  logic              illegal_next_s;
  logic [3:0]        alu_op_r;
  logic [CNT_W-1:0]  limit_r;
  logic [DATA_W-1:0] out_r;
  logic              alu_go_r;
  logic              busy_r;
  logic              out_valid_r;
  logic              timeout_r;
  logic              illegal_op_r;

  assign op_legal_s     = is_legal_op(bus.opr);
  assign accept_s       = (state_r == ST_IDLE) && bus.start && op_legal_s;
  assign timer_clear_s  = (state_r != ST_WAIT);
  assign timer_enable_s = (state_r == ST_WAIT) && !bus.done && !expired_s;

  op_timer #(.CNT_W(CNT_W)) u_op_timer (
    .clock   (clock),
    .reset   (reset),
    .clear   (timer_clear_s),
    .enable  (timer_enable_s),
    .limit   (limit_r),
    .expired (expired_s)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; done wins over an expiring counter in WAIT.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_next_s = ST_ISSUE;
        else          state_next_s = ST_IDLE;
      end
      ST_ISSUE: state_next_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.done || expired_s) state_next_s = ST_IDLE;
        else                       state_next_s = ST_WAIT;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Output decode: values the output registers take at the next edge.
  always_comb begin
    alu_go_next_s    = (state_next_s == ST_ISSUE);
    busy_next_s      = (state_next_s != ST_IDLE);
    out_valid_next_s = (state_r == ST_WAIT) && bus.done;
    timeout_next_s   = (state_r == ST_WAIT) && !bus.done && expired_s;
    illegal_next_s   = (state_r == ST_IDLE) && bus.start && !op_legal_s;
  end

  // Registered outputs and operation context (opcode, limit, result).
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_go_r     <= 1'b0;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
      timeout_r    <= 1'b0;
      illegal_op_r <= 1'b0;
      alu_op_r     <= 4'b0000;
      limit_r      <= '0;
      out_r        <= '0;
    end else begin
      alu_go_r     <= alu_go_next_s;
      busy_r       <= busy_next_s;
      out_valid_r  <= out_valid_next_s;
      timeout_r    <= timeout_next_s;
      illegal_op_r <= illegal_next_s;
      if (accept_s) begin
        alu_op_r <= bus.opr;
        limit_r  <= bus.maxclock;
      end else begin
        alu_op_r <= alu_op_r;
        limit_r  <= limit_r;
      end
      if (out_valid_next_s) out_r <= bus.alu_result;
      else                  out_r <= out_r;
    end
  end

  assign bus.alu_go     = alu_go_r;
  assign bus.alu_op     = alu_op_r;
  assign bus.busy       = busy_r;
  assign bus.out        = out_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.timeout    = timeout_r;
  assign bus.illegal_op = illegal_op_r;

endmodule

// File: doc/alu_op_controller.md
ALU_OP_CONTROLLER -- requirements
Module: alu_op_controller

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the ALU result and of out.
REQ-002 SHALL have parameter CNT_W, default 6, width of maxclock and the internal wait counter.
REQ-003 SHALL have port clock, input, 1, master clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1, request to launch an operation; sampled only in IDLE.
REQ-006 SHALL have port opr, input, 4, opcode; sampled with start.
REQ-007 SHALL have port maxclock, input, CNT_W, timeout limit; sampled with start.
REQ-008 SHALL have port done, input, 1, ALU completion strobe; sampled only in WAIT.
REQ-009 SHALL have port alu_result, input, DATA_W, ALU output; sampled when done is seen.
REQ-010 SHALL have port alu_go, output, 1, one-cycle launch pulse to the ALU.
REQ-011 SHALL have port alu_op, output, 4, latched opcode to the ALU.
REQ-012 SHALL have port busy, output, 1, high in ISSUE and WAIT.
REQ-013 SHALL have port out, output, DATA_W, registered result.
REQ-014 SHALL have port out_valid, output, 1, one-cycle pulse when out is updated.
REQ-015 SHALL have port timeout, output, 1, one-cycle pulse on an operation abandoned by timeout.
REQ-016 SHALL have port illegal_op, output, 1, one-cycle pulse on start with an unsupported opcode.

Function
REQ-017 SHALL accept legal opcodes 0000 (A), 0001 (B), 0010 (sum), 0011 (sub), 0100 (complex mul), 0110 (real mul), 1000 (A==B), 1001 (mod A) and 1010 (mod B); all other opcodes are illegal.
REQ-018 SHALL implement the FSM states IDLE, ISSUE and WAIT, using only these three.
REQ-019 SHALL, in IDLE with start=1 and a legal opr at a clock edge, latch opr into alu_op and maxclock into an internal limit, then enter ISSUE.
REQ-020 SHALL, in IDLE with start=1 and an illegal opr, pulse illegal_op for the next cycle and stay in IDLE, with no alu_go.
REQ-021 SHALL assert alu_go only during the single ISSUE cycle, then enter WAIT with counter=0.
REQ-022 SHALL, in WAIT with done=1, load out from alu_result, pulse out_valid in the following cycle and return to IDLE.
REQ-023 SHALL, in WAIT with done=0 and counter equal to the latched limit, pulse timeout in the following cycle, leave out unchanged and return to IDLE.
REQ-024 SHALL, in WAIT otherwise, increment counter; WAIT therefore lasts at most limit+1 cycles, and limit=0 gives exactly one WAIT cycle.
REQ-025 SHALL give done precedence when done=1 and counter equals the limit in the same cycle: out_valid, no timeout.
REQ-026 SHALL ignore done outside WAIT and ignore start outside IDLE, without raising an error flag.
REQ-027 SHALL accept start in the same cycle in which out_valid or timeout is high (back-to-back operations).
REQ-028 SHALL produce a minimum start-to-out_valid latency of 3 cycles (ISSUE, one WAIT cycle with done, out_valid cycle).
REQ-029 SHALL leave changes to maxclock or opr after acceptance without effect on the running operation.

Reset
REQ-030 SHALL, on reset=1 at a clock edge, force state=IDLE, counter=0, out=0, alu_op=0, and alu_go=busy=out_valid=timeout=illegal_op=0, overriding any operation in progress.
REQ-031 SHALL give reset priority over start and done in the same cycle.

Structure
REQ-032 SHALL place the opcode constants, the state encoding and the legal-opcode check function in a shared package, alu_ctrl_pkg.
REQ-033 SHALL place the wait counter and limit compare in one sub-module, op_timer, with clear, enable and expired ports.

Verification
REQ-034 SHALL cover reset: reset held 2 cycles -> out=0, busy=0, all pulse outputs 0.
REQ-035 SHALL cover a normal operation: start, opr=0010, maxclock=5, done on the 3rd WAIT cycle with alu_result=64'h0000_0005_0000_0007 -> alu_go high exactly 1 cycle, out=64'h0000_0005_0000_0007, out_valid high 1 cycle, busy low afterwards.
REQ-036 SHALL cover timeout: opr=0100, maxclock=2, done never asserted -> exactly 3 WAIT cycles, then a timeout pulse, out unchanged, out_valid stays 0.
REQ-037 SHALL cover an illegal opcode: start with opr=0101 -> illegal_op high 1 cycle, busy and alu_go stay 0.
REQ-038 SHALL cover the simultaneous boundary: maxclock=0 with done on the single WAIT cycle -> out_valid=1, timeout=0; then start with opr=1000 in the out_valid cycle -> alu_go on the next cycle.
REQ-039 SHALL cover reset and start while busy: reset in the 2nd WAIT cycle -> IDLE and out=0 next cycle; start asserted during WAIT -> no new alu_go and no error flag.
